uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-006 rx_data  output  8  last received byte, held until the next good frame.
REQ-007 rx_valid  output  1  one-cycle pulse when a good frame completes; rx_data is valid in the same cycle.
REQ-008 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 led  output  1  toggles on every rx_valid pulse.

Function
REQ-010 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-011 BIT_CNT_MAX SHALL be CLK_FREQ/BAUD-1 (5207 at defaults) and HALF_CNT SHALL be BIT_CNT_MAX/2 (2603).
REQ-012 rxd SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value rxd_s.
REQ-013 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-014 IDLE: on a falling edge of rxd_s (previous 1, current 0), go to START and clear the baud counter.
REQ-015 START: at baud count HALF_CNT, if the sample is 0, clear the counter (re-centre) and go to DATA; if it is 1 (glitch), return to IDLE with no output pulse.
REQ-016 DATA: at each baud count BIT_CNT_MAX, sample one bit into shift register position bit_cnt (0..7), then increment bit_cnt; after bit 7, go to STOP.
REQ-017 STOP: at baud count BIT_CNT_MAX, if the sample is 1, load rx_data, pulse rx_valid and go to IDLE; if it is 0, pulse frame_err, leave rx_data unchanged and go to IDLE.
REQ-018 rx_valid and frame_err SHALL assert on the cycle after the stop sample clock edge and SHALL never both be high.
REQ-019 A falling edge seen in IDLE immediately after STOP SHALL be accepted, supporting back-to-back frames with no idle gap.
REQ-020 A break (line held low) SHALL produce frame_err once, then wait in IDLE until rxd_s returns high before detecting the next start edge.
REQ-021 The baud counter SHALL be 13 bits wide, count only outside IDLE, and wrap to 0 at BIT_CNT_MAX.

Reset
REQ-022 While rst=0: state=IDLE, counters=0, rx_data=8'h00, rx_valid=0, frame_err=0, led=1, both synchronizer flops=1.
REQ-023 Asserting reset mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL resume at the next falling edge.

Configuration
REQ-024 Macro UART_RX_MAJORITY_EN: when defined, every sample (start, data, stop) SHALL be the 2-of-3 majority of rxd_s taken at counts SAMPLE-1, SAMPLE and SAMPLE+1 (SAMPLE = HALF_CNT in START, BIT_CNT_MAX otherwise), with the decision made at SAMPLE+1; when undefined, a single sample is taken at SAMPLE.
REQ-025 Output timing per REQ-018 SHALL be measured from the decision cycle in both builds.

Structure
REQ-026 Package uart_pkg SHALL hold the CLK_FREQ/BAUD defaults, the BIT_CNT_MAX and HALF_CNT computation, and the state enum typedef, shared with the transmitter.
REQ-027 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer and the falling-edge detect.

Verification
REQ-028 Send 8'h55 at 9600 baud -> exactly one rx_valid pulse with rx_data=8'h55, no frame_err, and led toggles to 0.
REQ-029 Drive rxd low for 1000 cycles, then high -> no rx_valid and no frame_err, and the FSM is back in IDLE.
REQ-030 Send 8'hA3 with the stop bit driven 0 -> one frame_err pulse, no rx_valid, and rx_data keeps its previous value.
REQ-031 Send 8'h00 then 8'hFF back-to-back with no gap -> two rx_valid pulses carrying 8'h00 then 8'hFF.
REQ-032 Assert rst during data bit 4 of a frame, release it, then send 8'h3C -> only one rx_valid, with 8'h3C.
REQ-033 With UART_RX_MAJORITY_EN defined, send 8'hF0 with a 1-cycle inverted glitch at the centre of every bit -> rx_data=8'hF0; without the macro, the same stimulus corrupts the byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default rates, baud counter limits and the receiver/transmitter FSM state type.
package uart_pkg;

   localparam int CLK_FREQ_DEF = 50_000_000;
   localparam int BAUD_DEF     = 9600;
   localparam int CNT_W        = 13;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   function automatic logic [CNT_W-1:0] bit_cnt_max(input int clk_freq, input int baud);
      return CNT_W'(clk_freq / baud - 1);
   endfunction

   function automatic logic [CNT_W-1:0] half_cnt(input int clk_freq, input int baud);
      return bit_cnt_max(clk_freq, baud) >> 1;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for rxd plus falling-edge detect and the per-cycle sample value.
// UART_RX_MAJORITY_EN: sample value becomes a 2-of-3 vote over the last three synchronized bits.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rxd,
   output logic fall,
   output logic vote
);

   logic meta;
   logic rxd_s;
   logic rxd_d;

   // NOTE: non-blocking assignments let the three flops shift in one edge without ordering hazards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta  <= 1'b1;
         rxd_s <= 1'b1;
         rxd_d <= 1'b1;
      end else begin
         meta  <= rxd;
         rxd_s <= meta;
         rxd_d <= rxd_s;
      end
   end

   assign fall = rxd_d & ~rxd_s;

`ifdef UART_RX_MAJORITY_EN
   logic rxd_d2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rxd_d2 <= 1'b1;
      else      rxd_d2 <= rxd_d;
   end

   // Values of rxd_s at the decision count and the two counts before it.
   assign vote = (rxd_s & rxd_d) | (rxd_s & rxd_d2) | (rxd_d & rxd_d2);
`else
   assign vote = rxd_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit re-centring, LSB-first data, stop-bit check, valid/error pulses and LED toggle.
// UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 vote, decided one count after the nominal sample point.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = CLK_FREQ_DEF,
   parameter int BAUD     = BAUD_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       led
);

   localparam logic [CNT_W-1:0] BIT_CNT_MAX = bit_cnt_max(CLK_FREQ, BAUD);
   localparam logic [CNT_W-1:0] HALF_CNT    = half_cnt(CLK_FREQ, BAUD);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [2:0]       bit_cnt, bit_cnt_nx;
   logic [7:0]       shift, shift_nx, rx_data_nx;
   logic             rx_valid_nx, frame_err_nx, led_nx;
   logic             fall, vote, wrap, bit_tick;
   logic [CNT_W-1:0] start_decide;

   uart_rx_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .rxd  (rxd),
      .fall (fall),
      .vote (vote)
   );

   assign wrap = (cnt == BIT_CNT_MAX);

`ifdef UART_RX_MAJORITY_EN
   logic tick_q;

   // Decision lands on the count after BIT_CNT_MAX, i.e. the first cycle after the counter wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tick_q <= 1'b0;
      else      tick_q <= wrap && (state == DATA || state == STOP);
   end

   assign bit_tick     = tick_q;
   assign start_decide = HALF_CNT + 1'b1;
`else
   assign bit_tick     = wrap;
   assign start_decide = HALF_CNT;
`endif

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_nx     = state;
      cnt_nx       = wrap ? '0 : cnt + 1'b1;
      bit_cnt_nx   = bit_cnt;
      shift_nx     = shift;
      rx_data_nx   = rx_data;
      rx_valid_nx  = 1'b0;
      frame_err_nx = 1'b0;
      led_nx       = led;
      case (state)
         IDLE: begin
            cnt_nx     = '0;
            bit_cnt_nx = '0;
            if (fall) state_nx = START;
         end
         START: begin
            if (cnt == start_decide) begin
               cnt_nx   = '0;
               state_nx = vote ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               shift_nx[bit_cnt] = vote;
               bit_cnt_nx        = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_nx = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               if (vote) begin
                  rx_data_nx  = shift;
                  rx_valid_nx = 1'b1;
                  led_nx      = ~led;
               end else begin
                  frame_err_nx = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: the shift register is small, so it is reset along with the rest rather than left undefined.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         led       <= 1'b1;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         bit_cnt   <= bit_cnt_nx;
         shift     <= shift_nx;
         rx_data   <= rx_data_nx;
         rx_valid  <= rx_valid_nx;
         frame_err <= frame_err_nx;
         led       <= led_nx;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a frame-level model queues expected pulses, a monitor pops and compares them.
// Honours UART_RX_MAJORITY_EN for the per-bit glitch frame.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CF         = 3_200_000;
   localparam int BD         = 100_000;
   localparam int BIT_CYC    = CF / BD;
   localparam int GLITCH_OFS = BIT_CYC / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam bit MAJ = 1'b1;
`else
   localparam bit MAJ = 1'b0;
`endif

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, led;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic       model_led;
   logic [7:0] model_data;

   uart_rx #(.CLK_FREQ(CF), .BAUD(BD)) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .led       (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   task automatic drive(input logic v, input int n);
      for (int c = 0; c < n; c++) begin
         rxd = v;
         @(posedge clk);
         #1;
      end
   endtask

   // Model: a good stop bit yields the byte (inverted by centre glitches without voting), a bad one an error.
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch);
      logic [9:0] bits;
      exp_t       e;
      bits   = {stop, b, 1'b0};
      e.err  = ~stop;
      e.data = (glitch && !MAJ) ? ~b : b;
      exp_q.push_back(e);
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < BIT_CYC; c++) begin
            rxd = bits[i] ^ (glitch && i >= 1 && i <= 8 && c == GLITCH_OFS);
            @(posedge clk);
            #1;
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         model_led  = 1'b1;
         model_data = 8'h00;
      end else if (rx_valid || frame_err) begin
         check("valid_err_exclusive", 32'(rx_valid & frame_err), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_is_err", 32'(frame_err), 32'(e.err));
            if (!e.err) begin
               model_data = e.data;
               model_led  = ~model_led;
            end
            check("rx_data", 32'(rx_data), 32'(model_data));
            check("led", 32'(led), 32'(model_led));
         end
      end
   end

   initial begin
      #(60_000 * 10);
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic       stop;
      int         gap;
      rst = 1'b0;
      rxd = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_rx_valid", 32'(rx_valid), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_led", 32'(led), 32'd1);
      rst = 1'b1;
      drive(1'b1, 2 * BIT_CYC);

      send_frame(8'h55, 1'b1, 1'b0);
      drive(1'b1, BIT_CYC);

      // Low pulse shorter than half a bit: rejected at the start-bit check.
      drive(1'b0, 10);
      drive(1'b1, 2 * BIT_CYC);
      check("idle_after_short_low", 32'(dut.state), 32'(IDLE));

      send_frame(8'hA3, 1'b0, 1'b0);
      drive(1'b1, 2 * BIT_CYC);

      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      drive(1'b1, 2 * BIT_CYC);

      // Break: exactly one frame error, then a normal frame once the line is back high.
      exp_q.push_back(exp_t'{err: 1'b1, data: 8'h00});
      drive(1'b0, 12 * BIT_CYC);
      check("idle_during_break", 32'(dut.state), 32'(IDLE));
      drive(1'b1, 2 * BIT_CYC);
      send_frame(8'h81, 1'b1, 1'b0);
      drive(1'b1, 2 * BIT_CYC);
      check("queue_empty_before_reset", exp_q.size(), 32'd0);

      // Abort mid data bit 4 with reset.
      b = 8'hC6;
      drive(1'b0, BIT_CYC);
      for (int i = 0; i < 4; i++) drive(b[i], BIT_CYC);
      drive(b[4], BIT_CYC / 2);
      rst = 1'b0;
      rxd = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("midreset_rx_data", 32'(rx_data), 32'h00);
      check("midreset_led", 32'(led), 32'd1);
      check("midreset_rx_valid", 32'(rx_valid), 32'd0);
      check("midreset_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b1;
      drive(1'b1, 2 * BIT_CYC);
      send_frame(8'h3C, 1'b1, 1'b0);
      drive(1'b1, BIT_CYC);

      send_frame(8'hF0, 1'b1, 1'b1);
      drive(1'b1, BIT_CYC);

      for (int n = 0; n < 10; n++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         gap  = $urandom_range(0, BIT_CYC);
         if (!stop && gap < 4) gap = 4;
         send_frame(b, stop, 1'b0);
         drive(1'b1, gap);
      end

      for (int i = 0; i < 4 * BIT_CYC && exp_q.size() != 0; i++) begin
         @(posedge clk);
      end
      #1;
      check("queue_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
